// File: rtl/hazard_fwd_ctrl_if.sv
// Handshake bundle between the ID/EX pipeline control and the hazard/forwarding controller.
// The pipeline side is the master; the controller is the slave.
interface hazard_fwd_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_wr;
  logic [4:0] id_rd;
  logic       id_load;
  logic       id_md_start;
  logic       id_use_hilo;
  logic       ex_branch_taken;
  logic       stall_if_id;
  logic       bubble_ex;
  logic       flush_if_id;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       md_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_rd,
           id_load, id_md_start, id_use_hilo, ex_branch_taken,
    input  stall_if_id, bubble_ex, flush_if_id, fwd_a_sel, fwd_b_sel, md_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_rd,
           id_load, id_md_start, id_use_hilo, ex_branch_taken,
    output stall_if_id, bubble_ex, flush_if_id, fwd_a_sel, fwd_b_sel, md_busy
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller: registered EX operand forwarding selects, load-use and mul/div stalls, branch flush.
// HAZ_FORWARD_EN defined enables forwarding; undefined, every EX/MEM dependence stalls and selects stay 00.
module hazard_fwd_ctrl #(
  parameter int MD_LATENCY = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  hazard_fwd_ctrl_if.slave hz
);
  localparam logic [7:0] LP_MD_LAT = 8'(MD_LATENCY);

  // Only fields with a consumer are kept: the register file is write-first, so WB is never
  // compared, and load-use only inspects the EX load flag.
  logic       r_ex_wr;
  logic [4:0] r_ex_rd;
  logic       r_ex_load;
  logic       r_mem_wr;
  logic [4:0] r_mem_rd;
  logic [7:0] r_md_cnt;

  logic w_a_ex, w_b_ex, w_a_mem, w_b_mem;
  logic w_load_use, w_dep_stall, w_md_busy, w_md_stall, w_any_stall;
  logic w_bubble, w_stall, w_md_load;

  assign w_a_ex  = hz.id_use_rs & r_ex_wr  & (r_ex_rd  != 5'd0) & (r_ex_rd  == hz.id_rs);
  assign w_b_ex  = hz.id_use_rt & r_ex_wr  & (r_ex_rd  != 5'd0) & (r_ex_rd  == hz.id_rt);
  assign w_a_mem = hz.id_use_rs & r_mem_wr & (r_mem_rd != 5'd0) & (r_mem_rd == hz.id_rs);
  assign w_b_mem = hz.id_use_rt & r_mem_wr & (r_mem_rd != 5'd0) & (r_mem_rd == hz.id_rt);

  assign w_load_use = hz.id_valid & r_ex_load & (w_a_ex | w_b_ex);

`ifdef HAZ_FORWARD_EN
  assign w_dep_stall = w_load_use;
`else
  assign w_dep_stall = w_load_use | (hz.id_valid & (w_a_ex | w_b_ex | w_a_mem | w_b_mem));
`endif

  assign w_md_busy   = (r_md_cnt != 8'd0);
  assign w_md_stall  = hz.id_valid & w_md_busy & (hz.id_use_hilo | hz.id_md_start);
  assign w_any_stall = w_dep_stall | w_md_stall;

  // A taken branch wins: the PC redirect must load, so the stall is dropped.
  assign w_bubble = ~i_rst & (hz.ex_branch_taken | w_any_stall);
  assign w_stall  = ~i_rst & ~hz.ex_branch_taken & w_any_stall;

  assign hz.flush_if_id = ~i_rst & hz.ex_branch_taken;
  assign hz.stall_if_id = w_stall;
  assign hz.bubble_ex   = w_bubble;
  assign hz.md_busy     = w_md_busy;

  assign w_md_load = hz.id_valid & hz.id_md_start & ~w_stall & ~hz.ex_branch_taken;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_wr   <= 1'b0;
      r_ex_rd   <= 5'd0;
      r_ex_load <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_mem_rd  <= 5'd0;
    end else begin
      r_mem_wr <= r_ex_wr;
      r_mem_rd <= r_ex_rd;
      if (hz.id_valid & ~w_bubble) begin
        r_ex_wr   <= hz.id_wr;
        r_ex_rd   <= hz.id_rd;
        r_ex_load <= hz.id_load;
      end else begin
        r_ex_wr   <= 1'b0;
        r_ex_rd   <= 5'd0;
        r_ex_load <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_md_cnt <= 8'd0;
    end else if (w_md_load) begin
      r_md_cnt <= LP_MD_LAT;
    end else if (r_md_cnt != 8'd0) begin
      r_md_cnt <= r_md_cnt - 8'd1;
    end
  end

`ifdef HAZ_FORWARD_EN
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;

  // The EX producer is younger than the MEM one, so it wins.
  function automatic logic [1:0] f_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return 2'b10;
    else if (mem_hit) return 2'b01;
    else              return 2'b00;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fwd_a <= 2'b00;
      r_fwd_b <= 2'b00;
    end else if (w_bubble) begin
      r_fwd_a <= 2'b00;
      r_fwd_b <= 2'b00;
    end else begin
      r_fwd_a <= f_sel(w_a_ex, w_a_mem);
      r_fwd_b <= f_sel(w_b_ex, w_b_mem);
    end
  end

  assign hz.fwd_a_sel = r_fwd_a;
  assign hz.fwd_b_sel = r_fwd_b;
`else
  assign hz.fwd_a_sel = 2'b00;
  assign hz.fwd_b_sel = 2'b00;
`endif
endmodule
